// File: rtl/alarma_crono_if.sv
// Trigger/stop inputs and buzzer/status outputs of the end-of-countdown alarm sequencer.
// master: port/status logic side; slave: alarma_crono.
interface alarma_crono_if;
  logic       fin_crono;
  logic       silenciar;
  logic       audio;
  logic       sonando;
  logic [3:0] beep_num;
  logic       fin_alarma;

  modport master (
    output fin_crono,
    output silenciar,
    input  audio,
    input  sonando,
    input  beep_num,
    input  fin_alarma
  );

  modport slave (
    input  fin_crono,
    input  silenciar,
    output audio,
    output sonando,
    output beep_num,
    output fin_alarma
  );
endinterface

// File: rtl/alarma_crono.sv
// Alarm beep sequencer: N_BEEPS tone bursts separated by silent gaps, started on a fin_crono edge.
// Optional build macro ALARMA_TONO_ALT_EN: even-numbered beeps sound one octave up.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | silent, waiting for a rising edge on fin_crono
// S_ON   | beep beep_num sounding, audio toggles every half period
// S_OFF  | silent gap after beep beep_num, audio held low
module alarma_crono #(
  parameter int TONE_HALF = 25000,
  parameter int BEEP_CYC  = 25000000,
  parameter int GAP_CYC   = 25000000,
  parameter int N_BEEPS   = 5
) (
  input  logic          reloj_nexys,
  input  logic          reset_total,
  alarma_crono_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic [15:0] TONE_TC_BASE = 16'(TONE_HALF - 1);
  localparam logic [26:0] BEEP_TC      = 27'(BEEP_CYC - 1);
  localparam logic [26:0] GAP_TC       = 27'(GAP_CYC - 1);
  localparam logic [3:0]  N_B          = 4'(N_BEEPS);

  logic        reset_interno;
  logic [1:0]  state, state_nx;
  logic [15:0] tone, tone_nx, tone_tc;
  logic [26:0] phase, phase_nx;
  logic [3:0]  beep_q, beep_nx;
  logic        audio_q, audio_nx;
  logic        sonando_q;
  logic        fin_q, fin_nx;
  logic        fin_ant;
  logic        trig;

  assign reset_interno = reset_total;
  assign trig          = bus.fin_crono & ~fin_ant;

`ifdef ALARMA_TONO_ALT_EN
  localparam logic [15:0] TONE_TC_ALT = 16'((TONE_HALF / 2) - 1);
  assign tone_tc = beep_q[0] ? TONE_TC_BASE : TONE_TC_ALT;
`else
  assign tone_tc = TONE_TC_BASE;
`endif

  always_comb begin
    state_nx = state;
    tone_nx  = tone;
    phase_nx = phase;
    beep_nx  = beep_q;
    audio_nx = audio_q;
    fin_nx   = 1'b0;

    if (bus.silenciar) begin
      state_nx = S_IDLE;
      tone_nx  = '0;
      phase_nx = '0;
      beep_nx  = '0;
      audio_nx = 1'b0;
    end else if (trig) begin
      // Restart from beep 1 whatever the current state; no completion pulse.
      state_nx = S_ON;
      tone_nx  = '0;
      phase_nx = '0;
      beep_nx  = 4'd1;
      audio_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tone_nx  = '0;
          phase_nx = '0;
          beep_nx  = '0;
          audio_nx = 1'b0;
        end

        S_ON: begin
          if (tone == tone_tc) begin
            tone_nx  = '0;
            audio_nx = ~audio_q;
          end else begin
            tone_nx = tone + 16'd1;
          end

          if (phase == BEEP_TC) begin
            tone_nx  = '0;
            phase_nx = '0;
            audio_nx = 1'b0;
            if (beep_q < N_B) begin
              state_nx = S_OFF;
            end else begin
              state_nx = S_IDLE;
              beep_nx  = '0;
              fin_nx   = 1'b1;
            end
          end else begin
            phase_nx = phase + 27'd1;
          end
        end

        S_OFF: begin
          tone_nx  = '0;
          audio_nx = 1'b0;
          if (phase == GAP_TC) begin
            state_nx = S_ON;
            phase_nx = '0;
            beep_nx  = beep_q + 4'd1;
          end else begin
            phase_nx = phase + 27'd1;
          end
        end

        default: begin
          state_nx = S_IDLE;
          tone_nx  = '0;
          phase_nx = '0;
          beep_nx  = '0;
          audio_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge reloj_nexys) begin
    if (reset_interno) begin
      state     <= S_IDLE;
      tone      <= '0;
      phase     <= '0;
      beep_q    <= '0;
      audio_q   <= 1'b0;
      sonando_q <= 1'b0;
      fin_q     <= 1'b0;
      fin_ant   <= 1'b0;
    end else begin
      state     <= state_nx;
      tone      <= tone_nx;
      phase     <= phase_nx;
      beep_q    <= beep_nx;
      audio_q   <= audio_nx;
      sonando_q <= (state_nx != S_IDLE);
      fin_q     <= fin_nx;
      fin_ant   <= bus.fin_crono;
    end
  end

  assign bus.audio      = audio_q;
  assign bus.sonando    = sonando_q;
  assign bus.beep_num   = beep_q;
  assign bus.fin_alarma = fin_q;

endmodule

// File: tb/tb_alarma_crono.sv
// Bench for alarma_crono: directed scenarios then random triggers/stops/resets,
// every cycle compared with a time-since-start model of the beep pattern.
module tb_alarma_crono;
  localparam int TH      = 4;
  localparam int BC      = 40;
  localparam int GC      = 20;
  localparam int NB      = 3;
  localparam int PER     = BC + GC;
  localparam int SEQ_LEN = NB * BC + (NB - 1) * GC;

  logic reloj_nexys = 1'b0;
  logic reset_total;

  alarma_crono_if bus ();

  alarma_crono #(
    .TONE_HALF (TH),
    .BEEP_CYC  (BC),
    .GAP_CYC   (GC),
    .N_BEEPS   (NB)
  ) dut (
    .reloj_nexys (reloj_nexys),
    .reset_total (reset_total),
    .bus         (bus)
  );

  always #5 reloj_nexys = ~reloj_nexys;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fin_count   = 0;
  int last_fin    = -1;
  int entry_cyc   = 0;

  // Reference: active flag plus cycles elapsed since the sequence started.
  bit m_active = 1'b0;
  bit m_prev   = 1'b0;
  bit m_fin    = 1'b0;
  int m_t      = 0;

  function automatic int half_of(input int beep);
`ifdef ALARMA_TONO_ALT_EN
    return (beep % 2 == 0) ? TH / 2 : TH;
`else
    return TH;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit f, s, r, trig;
    int k, ph, beep, aud;
    f = bus.fin_crono;
    s = bus.silenciar;
    r = reset_total;
    @(posedge reloj_nexys);
    cyc++;
    m_fin = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
      m_t      = 0;
    end else begin
      trig   = f & ~m_prev;
      m_prev = f;
      if (s) m_active = 1'b0;
      else if (trig) begin
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t == SEQ_LEN) begin
          m_active = 1'b0;
          m_fin    = 1'b1;
        end
      end
    end
    #1;
    if (m_active) begin
      k    = m_t / PER;
      ph   = m_t % PER;
      beep = k + 1;
      aud  = (ph < BC) ? ((ph / half_of(beep)) % 2) : 0;
    end else begin
      beep = 0;
      aud  = 0;
    end
    check("sonando",    32'(bus.sonando),    32'(m_active));
    check("beep_num",   32'(bus.beep_num),   32'(beep));
    check("audio",      32'(bus.audio),      32'(aud));
    check("fin_alarma", 32'(bus.fin_alarma), 32'(m_fin));
    if (bus.fin_alarma === 1'b1) begin
      fin_count++;
      last_fin = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    bus.fin_crono = 1'b1;
    step();
    entry_cyc = cyc;
    bus.fin_crono = 1'b0;
  endtask

  initial begin
    reset_total   = 1'b1;
    bus.fin_crono = 1'b1;
    bus.silenciar = 1'b0;

    // Reset with fin_crono high, then release: cleared edge register gives one trigger.
    run(3);
    reset_total = 1'b0;
    step();
    check("post_reset_trigger", 32'(bus.sonando), 32'd1);
    bus.fin_crono = 1'b0;
    fin_count = 0;
    run(SEQ_LEN + 5);
    check("post_reset_fin_count", 32'(fin_count), 32'd1);

    // Normal single-pulse run.
    fin_count = 0;
    run(4);
    pulse();
    run(SEQ_LEN + 10);
    check("normal_fin_count", 32'(fin_count), 32'd1);
    check("normal_fin_time", 32'(last_fin), 32'(entry_cyc + SEQ_LEN));

    // Level held for 300 cycles triggers exactly once.
    fin_count = 0;
    bus.fin_crono = 1'b1;
    run(300);
    bus.fin_crono = 1'b0;
    run(5);
    check("held_fin_count", 32'(fin_count), 32'd1);

    // Silence during beep 2.
    fin_count = 0;
    pulse();
    run(PER + 5);
    check("silence_at_beep2", 32'(bus.beep_num), 32'd2);
    bus.silenciar = 1'b1;
    step();
    bus.silenciar = 1'b0;
    check("silence_beep_num", 32'(bus.beep_num), 32'd0);
    check("silence_audio", 32'(bus.audio), 32'd0);
    run(SEQ_LEN + 20);
    check("silence_fin_count", 32'(fin_count), 32'd0);

    // Retrigger in the gap after beep 1.
    fin_count = 0;
    pulse();
    run(BC + 5);
    pulse();
    check("retrig_beep_num", 32'(bus.beep_num), 32'd1);
    run(SEQ_LEN + 10);
    check("retrig_fin_count", 32'(fin_count), 32'd1);
    check("retrig_fin_time", 32'(last_fin), 32'(entry_cyc + SEQ_LEN));

    // Silence and trigger together from idle.
    bus.fin_crono = 1'b1;
    bus.silenciar = 1'b1;
    step();
    check("sil_priority", 32'(bus.sonando), 32'd0);
    bus.fin_crono = 1'b0;
    bus.silenciar = 1'b0;
    run(3);

    // Reset in the middle of beep 2.
    fin_count = 0;
    pulse();
    run(PER + 5);
    reset_total = 1'b1;
    step();
    reset_total = 1'b0;
    check("reset_mid_sonando", 32'(bus.sonando), 32'd0);
    check("reset_mid_beep", 32'(bus.beep_num), 32'd0);
    run(SEQ_LEN);
    check("reset_mid_fin_count", 32'(fin_count), 32'd0);

    // Random triggers, stops and resets.
    for (int i = 0; i < 4000; i++) begin
      bus.fin_crono = ($urandom_range(0, 149) == 0);
      bus.silenciar = ($urandom_range(0, 599) == 0);
      reset_total   = ($urandom_range(0, 1999) == 0);
      step();
    end
    bus.fin_crono = 1'b0;
    bus.silenciar = 1'b0;
    reset_total   = 1'b0;
    run(SEQ_LEN + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
